det_count_scan: RTL

- Downstream stage of the sequence-detector FSM. Counts rising edges of the detector's `count` flag into a 4-digit BCD total (0000–9999).
- Drives the board's 4-digit seven-segment display by time-multiplexing. This replaces static single-digit decode and switch-driven anodes.
- Runs on the 100 MHz board clock. The detector flag comes from the debounced-button clock domain, so it is synchronised here.

---
 rtl/det_pkg.sv | 41 ++++
 rtl/det_count_scan_if.sv | 16 +
 rtl/bcd_cnt4.sv | 46 ++++
 rtl/det_count_scan.sv | 86 ++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared constants, types and the segment glyph lookup for the
// detection counter / seven-segment scan block.
package det_pkg;

  localparam int SCAN_DIV_DEF = 100000;

  // Packed BCD total: element [0] is units, element [3] is thousands.
  typedef logic [3:0][3:0] bcd4_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [7:0] seg_glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/det_count_scan_if.sv
// Detector-flag / display bundle between the counter-scan block and its user.
interface det_count_scan_if;
  import det_pkg::*;

  logic       hit;
  logic       clr;
  logic       blank_lz;
  bcd4_t      total;
  logic       ovf;
  logic [3:0] an;
  logic [7:0] sseg;

  modport master (output hit, clr, blank_lz, input total, ovf, an, sseg);
  modport slave  (input hit, clr, blank_lz, output total, ovf, an, sseg);

endinterface

// File: rtl/bcd_cnt4.sv
// Four-digit BCD up-counter with synchronous clear and a one-cycle wrap flag.
module bcd_cnt4
  import det_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  clr,
  output bcd4_t value,
  output logic  ovf
);

  bcd4_t value_inc;
  logic  carry;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    value_inc = value;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[i] == 4'd9) begin
          value_inc[i] = 4'd0;
        end else begin
          value_inc[i] = value[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  // carry survives the loop only when every digit was 9, i.e. 9999 -> 0000.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= inc & carry;
      if (inc) value <= value_inc;
    end
  end

endmodule

// File: rtl/det_count_scan.sv
// Counts synchronised rising edges of the detector flag into a BCD total and
// time-multiplexes that total onto a 4-digit active-low seven-segment display.
module det_count_scan
  import det_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DIV_W    = 17
) (
  input  logic            clk,
  input  logic            rst,
  det_count_scan_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic             s1, s2, prev, pulse;
  bcd4_t            total;
  logic             ovf;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [3:0]       lead_zero;
  logic [3:0]       an_q;
  logic [7:0]       sseg_q;

  // NOTE: sequential state uses non-blocking assignments so s1->s2->prev
  // shift as a true pipeline. The whole chain resets high so a flag already
  // high at reset release looks like a steady level, not a fresh rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= bus.hit;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign pulse = s2 & ~prev;

  bcd_cnt4 u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pulse),
    .clr   (bus.clr),
    .value (total),
    .ovf   (ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (total[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (total[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (total[1] == 4'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q   <= 4'b1110;
      sseg_q <= SEG_0;
    end else begin
      an_q   <= AN_OFF ^ (4'b0001 << idx);
      sseg_q <= (bus.blank_lz && lead_zero[idx]) ? SEG_BLANK : seg_glyph(total[idx]);
    end
  end

  assign bus.total = total;
  assign bus.ovf   = ovf;
  assign bus.an    = an_q;
  assign bus.sseg  = sseg_q;

endmodule
